// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encodings,
// flag bundle, full-adder cell and the saturation constant helper.
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MAX_W = 64;

  // Flag bundle, MSB first: {ovf, carry, zero, neg}
  typedef struct packed {
    logic ovf;
    logic carry;
    logic zero;
    logic neg;
  } flags_t;

  // One-bit full adder, returns {cout, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Clamp value for a w-bit signed result: positive max when msb=0, negative min when msb=1
  function automatic logic [MAX_W-1:0] sat_val(input logic msb, input int unsigned w);
    logic [MAX_W-1:0] top;
    top = MAX_W'(1) << (w - 1);
    return msb ? top : (top - MAX_W'(1));
  endfunction

endpackage

// File: rtl/add_sub_seg.sv
// SEG-bit ripple add/sub segment; B is conditionally inverted, carry-in supplied
// by the caller. Also exports the segment MSB of the inverted B for overflow.
module add_sub_seg
  import add_sub_pkg::*;
#(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           sub,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           bx_msb
);

  logic [SEG-1:0] bx;

  assign bx     = b ^ {SEG{sub == OP_SUB}};
  assign bx_msb = bx[SEG-1];

  always_comb begin
    logic [1:0] fa;
    logic       cc;
    cc = cin;
    s  = '0;
    fa = '0;
    for (int i = 0; i < int'(SEG); i++) begin
      fa   = full_add(a[i], bx[i], cc);
      s[i] = fa[0];
      cc   = fa[1];
    end
    cout = cc;
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined W-bit two's-complement add/sub, one carry segment per stage, valid/ready.
// Optional clamp on signed overflow when PIPE_ADD_SUB_SATURATE_EN is defined.
module pipe_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         ovf,
  output logic         carry,
  output logic         zero,
  output logic         neg
);

  localparam int unsigned SEG  = W / STAGES;
  localparam int unsigned MID  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned LAST = STAGES - 1;

  logic en;

  // Inter-stage registers: skew (a, b), deskew (s), carry, opcode, valid
  logic [W-1:0] a_q   [MID];
  logic [W-1:0] b_q   [MID];
  logic [W-1:0] s_q   [MID];
  logic         c_q   [MID];
  logic         sub_q [MID];
  logic         v_q   [MID];

  // Per-stage combinational view
  logic [W-1:0]   a_st   [STAGES];
  logic [W-1:0]   b_st   [STAGES];
  logic [W-1:0]   s_st   [STAGES];
  logic [W-1:0]   s_nxt  [STAGES];
  logic           cin_st [STAGES];
  logic           sub_st [STAGES];
  logic [SEG-1:0] seg_s  [STAGES];
  logic           seg_c  [STAGES];
  logic           seg_bxm[STAGES];

  logic         last_v;
  logic [W-1:0] r_fin;
  flags_t       flags_d;
  flags_t       flags_q;
  logic [W-1:0] r_q;
  logic         out_valid_q;

  // Whole pipe advances together; bubbles move like beats
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam logic [W-1:0] MASK = W'({SEG{1'b1}}) << (k * SEG);

    if (k == 0) begin : g_first
      assign a_st[k]   = a;
      assign b_st[k]   = b;
      assign s_st[k]   = '0;
      assign sub_st[k] = sub;
      assign cin_st[k] = sub;
    end else begin : g_next
      assign a_st[k]   = a_q[k-1];
      assign b_st[k]   = b_q[k-1];
      assign s_st[k]   = s_q[k-1];
      assign sub_st[k] = sub_q[k-1];
      assign cin_st[k] = c_q[k-1];
    end

    add_sub_seg #(.SEG(SEG)) u_seg (
      .a      (a_st[k][k*SEG +: SEG]),
      .b      (b_st[k][k*SEG +: SEG]),
      .cin    (cin_st[k]),
      .sub    (sub_st[k]),
      .s      (seg_s[k]),
      .cout   (seg_c[k]),
      .bx_msb (seg_bxm[k])
    );

    assign s_nxt[k] = (s_st[k] & ~MASK) | (W'(seg_s[k]) << (k * SEG));
  end

  if (STAGES > 1) begin : g_mid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < int'(MID); k++) begin
          a_q[k]   <= '0;
          b_q[k]   <= '0;
          s_q[k]   <= '0;
          c_q[k]   <= 1'b0;
          sub_q[k] <= 1'b0;
          v_q[k]   <= 1'b0;
        end
      end else if (en) begin
        v_q[0] <= in_valid;
        for (int k = 1; k < int'(MID); k++) begin
          v_q[k] <= v_q[k-1];
        end
        for (int k = 0; k < int'(MID); k++) begin
          a_q[k]   <= a_st[k];
          b_q[k]   <= b_st[k];
          s_q[k]   <= s_nxt[k];
          c_q[k]   <= seg_c[k];
          sub_q[k] <= sub_st[k];
        end
      end
    end
    assign last_v = v_q[MID-1];
  end else begin : g_flat
    always_comb begin
      for (int k = 0; k < int'(MID); k++) begin
        a_q[k]   = '0;
        b_q[k]   = '0;
        s_q[k]   = '0;
        c_q[k]   = 1'b0;
        sub_q[k] = 1'b0;
        v_q[k]   = 1'b0;
      end
    end
    assign last_v = in_valid;
  end

  // Flags from the completed W-bit result in the final stage
  always_comb begin
    flags_d       = '0;
    r_fin         = '0;
    flags_d.ovf   = (a_st[LAST][W-1] & seg_bxm[LAST] & ~s_nxt[LAST][W-1]) |
                    (~a_st[LAST][W-1] & ~seg_bxm[LAST] & s_nxt[LAST][W-1]);
    flags_d.carry = seg_c[LAST];
`ifdef PIPE_ADD_SUB_SATURATE_EN
    r_fin = flags_d.ovf ? W'(sat_val(a_st[LAST][W-1], W)) : s_nxt[LAST];
`else
    r_fin = s_nxt[LAST];
`endif
    flags_d.zero  = (r_fin == '0);
    flags_d.neg   = r_fin[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= last_v;
      r_q         <= r_fin;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign ovf       = flags_q.ovf;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub: random and directed beats checked against
// a signed/unsigned arithmetic reference model; monitor pops on each output transfer.
module tb_pipe_add_sub;

  localparam int unsigned W      = 16;
  localparam int unsigned STAGES = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic ovf;
    logic carry;
    logic zero;
    logic neg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] r;
  logic         ovf, carry, zero, neg;

  pipe_add_sub #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .ovf(ovf), .carry(carry), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   acc_hist[0:8191];
  int   mode = 0;
  int   stall_lo = 0;
  int   stall_hi = 0;
  bit   track_on = 1'b0;
  int   track_start = 0;
  bit   prev_stall = 1'b0;
  logic [W-1:0] prev_r = '0;
  int   stall_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: true signed result, range check for overflow, unsigned compare for carry
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t   e;
    longint sx, sy, ux, uy, res, maxv, minv;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'(x);
    uy   = longint'(y);
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    res  = s ? (sx - sy) : (sx + sy);
    e.ovf   = (res > maxv) || (res < minv);
    e.r     = W'(res);
    e.carry = s ? (ux >= uy) : ((ux + uy) >= (longint'(1) << W));
`ifdef PIPE_ADD_SUB_SATURATE_EN
    if (e.ovf) e.r = (res > maxv) ? W'(maxv) : W'(minv);
`endif
    e.zero = (e.r == '0);
    e.neg  = e.r[W-1];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endcase
  end

  // Monitor: handshake rules, stall stability, valid pattern, scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      acc_hist[cyc % 8192] = in_valid && in_ready;
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(out_valid), 64'(1));
        chk("stall_hold_r", 64'(r), 64'(prev_r));
      end
      if (track_on && cyc >= track_start + int'(STAGES))
        chk("valid_pattern", 64'(out_valid), 64'(acc_hist[(cyc - int'(STAGES)) % 8192]));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got r=%0h with no beat pending (cycle %0d)", r, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({r, ovf, carry, zero, neg}), 64'(e));
        end
      end
      if (out_valid && !out_ready) stall_seen++;
      prev_stall = out_valid && !out_ready;
      prev_r     = r;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int t_acc);
    int tries;
    bit done;
    tries = 0;
    done  = 1'b0;
    t_acc = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(x, y, s));
        t_acc = cyc;
        done  = 1'b1;
      end else if (++tries > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %0b for 200 cycles, required 1", in_ready);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  // Single beat into an empty pipe: check latency and the spec's literal result
  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [W-1:0] er, input logic [3:0] ef);
    int t0, w;
    send(x, y, s, t0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 50);
    chk("latency", 64'(cyc - t0), 64'(STAGES));
    chk("directed_r", 64'(r), 64'(er));
    chk("directed_flags", 64'({ovf, carry, zero, neg}), 64'(ef));
    @(posedge clk);
    #1;
    idle(2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_first, t_last;
    logic [W-1:0] x, y;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_r", 64'(r), 64'(0));
    chk("reset_flags", 64'({ovf, carry, zero, neg}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic cases
    directed(16'h1234, 16'h0001, 1'b0, 16'h1235, 4'b0000);
    directed(16'h00FF, 16'h00FF, 1'b1, 16'h0000, 4'b0110);
    directed(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0001);
`ifdef PIPE_ADD_SUB_SATURATE_EN
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b1000);
    directed(16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b1101);
`else
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001);
    directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100);
`endif

    // Back-pressure window while streaming 8 beats
    stall_lo = cyc + 5;
    stall_hi = cyc + 9;
    mode = 2;
    for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, t0);
    drain();
    chk("stall_observed", 64'(stall_seen > 0), 64'(1));
    mode = 0;
    idle(STAGES + 2);

    // Bubbles then a full-rate burst
    track_start = cyc;
    track_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) send(W'($urandom), W'($urandom), 1'($urandom), t0);
      else idle(1);
    end
    for (int i = 0; i < 16; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), t0);
      if (i == 0) t_first = t0;
      if (i == 15) t_last = t0;
    end
    chk("throughput", 64'(t_last - t_first), 64'(15));
    drain();
    idle(STAGES + 2);
    track_on = 1'b0;

    // Random operands with random back-pressure
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: x = 16'h7FFF;
        1: x = 16'h8000;
        2: x = 16'hFFFF;
        default: x = W'($urandom);
      endcase
      y = ($urandom_range(0, 5) == 0) ? x : W'($urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(x, y, 1'($urandom), t0);
    end
    drain();
    mode = 0;
    idle(STAGES + 2);

    // Asynchronous reset with beats in flight
    for (int i = 0; i < 5; i++) send(W'(16'h0100 + i), W'(16'h0011), 1'b0, t0);
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_r", 64'(r), 64'(0));
    chk("async_rst_flags", 64'({ovf, carry, zero, neg}), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_stale_beat", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    directed(16'h1234, 16'h0001, 1'b0, 16'h1235, 4'b0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
